// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: FSM encoding and
// the tenure-counter sizing rule.
package rr_mux_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // One spare bit above clog2 keeps the counter from ever wrapping, even for MAX_HOLD=1.
  function automatic int unsigned hold_width(input int unsigned max_hold);
    return $clog2(max_hold) + 1;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// Rotating-priority finder: first set request strictly after ptr, wrapping,
// found with a priority scan over a doubled request vector.
module rr_mux_arbiter_pick #(
  parameter int REQ_NUM = 4,
  parameter int SEL_LEN = 2
) (
  input  logic [REQ_NUM-1:0] req_i,
  input  logic [SEL_LEN-1:0] ptr_i,
  output logic               any_o,
  output logic [SEL_LEN-1:0] winner_o
);

  localparam int IDX_W = $clog2(2 * REQ_NUM);

  logic [2*REQ_NUM-1:0] req_dbl;
  logic                 found;

  assign req_dbl = {req_i, req_i};

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    found    = 1'b0;
    winner_o = ptr_i;
    // Scanning ptr+1 .. ptr+REQ_NUM in the doubled vector handles wrap-around without a modulo on the select path.
    for (int k = 1; k <= REQ_NUM; k++) begin
      if (!found && req_dbl[IDX_W'(int'(ptr_i) + k)]) begin
        found    = 1'b1;
        winner_o = SEL_LEN'((int'(ptr_i) + k) % REQ_NUM);
      end
    end
  end

  assign any_o = found;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter owning a shared N:1 data mux; each tenure is capped at
// MAX_HOLD cycles and handover between requesters has no idle bubble.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int REQ_NUM  = 4,
  parameter int SEL_LEN  = 2,
  parameter int DATA_LEN = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [REQ_NUM-1:0]          req,
  input  logic [REQ_NUM*DATA_LEN-1:0] data_in,
  output logic [REQ_NUM-1:0]          gnt,
  output logic [SEL_LEN-1:0]          sel,
  output logic                        valid,
  output logic [DATA_LEN-1:0]         out
);

  localparam int                  HOLD_W    = hold_width(MAX_HOLD);
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [SEL_LEN-1:0]  PTR_RST   = SEL_LEN'(REQ_NUM - 1);

  arb_state_e           state_q, state_d;
  logic [REQ_NUM-1:0]   gnt_q,   gnt_d;
  logic [SEL_LEN-1:0]   sel_q,   sel_d;
  logic                 valid_q, valid_d;
  logic [SEL_LEN-1:0]   ptr_q,   ptr_d;
  logic [HOLD_W-1:0]    hold_q,  hold_d;

  logic                 pick_any;
  logic [SEL_LEN-1:0]   pick_winner;
  logic                 owner_req;
  logic                 others_pending;
  logic                 expire;

  logic [DATA_LEN-1:0]  data_arr [REQ_NUM];

  rr_mux_arbiter_pick #(
    .REQ_NUM (REQ_NUM),
    .SEL_LEN (SEL_LEN)
  ) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .any_o    (pick_any),
    .winner_o (pick_winner)
  );

  assign owner_req      = req[sel_q];
  assign others_pending = |(req & ~gnt_q);
  assign expire         = (hold_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_GRANT;
          gnt_d   = REQ_NUM'(1) << pick_winner;
          sel_d   = pick_winner;
          valid_d = 1'b1;
          ptr_d   = pick_winner;
          hold_d  = '0;
        end
      end
      ST_GRANT: begin
        if (owner_req && !expire) begin
          hold_d = hold_q + HOLD_W'(1);
        end else if (others_pending) begin
          // ptr always equals the owner here, so the pick already skips it.
          gnt_d  = REQ_NUM'(1) << pick_winner;
          sel_d  = pick_winner;
          ptr_d  = pick_winner;
          hold_d = '0;
        end else if (owner_req) begin
          hold_d = '0;
        end else begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          valid_d = 1'b0;
          hold_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= PTR_RST;
      hold_q  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values, independent of statement order.
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  for (genvar i = 0; i < REQ_NUM; i++) begin : g_data
    assign data_arr[i] = data_in[i*DATA_LEN +: DATA_LEN];
  end

  // Output mux defaults to zero whenever no grant is held.
  assign out   = valid_q ? data_arr[sel_q] : '0;
  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign valid = valid_q;

endmodule
